if_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register of St.PU.
- Holds the PC and drives a single-outstanding request/grant/response instruction bus.
- Registers the fetched word and its PC for the ID stage.
- Honours ID stall (holds output) and flush/redirect (branch/exception), inserting NOP bubbles when no instruction is ready.

---
 rtl/if_stage_if.sv | 24 ++
 rtl/if_stage.sv | 127 ++++++++++++
 tb/tb_if_stage.sv | 134 +++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - single-outstanding request/grant/response instruction bus
interface if_stage_if;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_gnt_i;
  logic        inst_rvalid_i;
  logic [31:0] inst_rdata_i;

  modport master (
    output inst_req_o,
    output inst_addr_o,
    input  inst_gnt_i,
    input  inst_rvalid_i,
    input  inst_rdata_i
  );

  modport slave (
    input  inst_req_o,
    input  inst_addr_o,
    output inst_gnt_i,
    output inst_rvalid_i,
    output inst_rdata_i
  );
endinterface

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with IF/ID pipeline register
// One fetch in flight; a one-entry buffer absorbs a response that arrives while ID stalls.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] redirect_pc_i,
  if_stage_if.master  bus,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DROP} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] fetch_pc, fetch_pc_n;
  logic [31:0] buf_pc, buf_inst;
  logic        buf_load;
  logic        deliver;
  logic [31:0] dlv_pc, dlv_inst;

  assign bus.inst_req_o  = (state == REQ);
  assign bus.inst_addr_o = pc;

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    fetch_pc_n = fetch_pc;
    buf_load   = 1'b0;
    deliver    = 1'b0;
    dlv_pc     = fetch_pc;
    dlv_inst   = bus.inst_rdata_i;
    if (flush_i) begin
      pc_n = redirect_pc_i & 32'hFFFF_FFFC;
      // A granted or still-pending fetch must have its response swallowed in DROP.
      case (state)
        REQ:       state_n = bus.inst_gnt_i ? DROP : REQ;
        WAIT,
        DROP:      state_n = bus.inst_rvalid_i ? REQ : DROP;
        default:   state_n = REQ;
      endcase
    end else begin
      case (state)
        IDLE: state_n = REQ;
        REQ: begin
          if (bus.inst_gnt_i) begin
            state_n    = WAIT;
            fetch_pc_n = pc;
          end
        end
        WAIT: begin
          if (bus.inst_rvalid_i) begin
            pc_n = fetch_pc + 32'd4;
            if (stall_i) begin
              buf_load = 1'b1;
              state_n  = HOLD;
            end else begin
              deliver = 1'b1;
              state_n = REQ;
            end
          end
        end
        HOLD: begin
          if (!stall_i) begin
            deliver  = 1'b1;
            dlv_pc   = buf_pc;
            dlv_inst = buf_inst;
            state_n  = REQ;
          end
        end
        DROP: begin
          if (bus.inst_rvalid_i) state_n = REQ;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      fetch_pc <= RESET_PC;
      buf_pc   <= 32'h0;
      buf_inst <= NOP_INST;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      fetch_pc <= fetch_pc_n;
      if (flush_i) begin
        buf_pc   <= 32'h0;
        buf_inst <= NOP_INST;
      end else if (buf_load) begin
        buf_pc   <= fetch_pc;
        buf_inst <= bus.inst_rdata_i;
      end
    end
  end

  // Bubbles keep the last pc_o so ID always sees a plausible PC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_o         <= 32'h0;
      inst_o       <= NOP_INST;
      inst_valid_o <= 1'b0;
    end else if (flush_i) begin
      inst_o       <= NOP_INST;
      inst_valid_o <= 1'b0;
    end else if (!stall_i) begin
      if (deliver) begin
        pc_o         <= dlv_pc;
        inst_o       <= dlv_inst;
        inst_valid_o <= 1'b1;
      end else begin
        inst_o       <= NOP_INST;
        inst_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed cycle-vector bench for if_stage
// Each vector: inputs driven after the falling edge, outputs of that cycle checked 1ns later.
module tb_if_stage;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] redir;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic [31:0] pc_o, inst_o;
  logic        inst_valid_o;
  int          n_checks = 0;
  int          n_pass = 0;
  vec_t        vecs[$];
  vec_t        hand[$];

  if_stage_if bus ();

  if_stage #(.RESET_PC(32'h0000_0000), .NOP_INST(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .redirect_pc_i (redirect_pc_i),
    .bus           (bus),
    .pc_o          (pc_o),
    .inst_o        (inst_o),
    .inst_valid_o  (inst_valid_o)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic st, input logic fl, input logic [31:0] rd,
                              input logic g, input logic rv, input logic [31:0] dat,
                              input logic q, input logic [31:0] a, input logic [31:0] p,
                              input logic [31:0] i, input logic v);
    vec_t t;
    t.rst = r; t.stall = st; t.flush = fl; t.redir = rd;
    t.gnt = g; t.rvalid = rv; t.rdata = dat;
    t.req = q; t.addr = a; t.pc = p; t.inst = i; t.valid = v;
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s step %0d: got %h want %h", name, idx, got, want);
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    rst               = v.rst;
    stall_i           = v.stall;
    flush_i           = v.flush;
    redirect_pc_i     = v.redir;
    bus.inst_gnt_i    = v.gnt;
    bus.inst_rvalid_i = v.rvalid;
    bus.inst_rdata_i  = v.rdata;
    #1;
    chk("inst_req", idx, {31'd0, bus.inst_req_o}, {31'd0, v.req});
    chk("inst_addr", idx, bus.inst_addr_o, v.addr);
    chk("pc_o", idx, pc_o, v.pc);
    chk("inst_o", idx, inst_o, v.inst);
    chk("inst_valid", idx, {31'd0, inst_valid_o}, {31'd0, v.valid});
  endtask

  initial begin
    bus.inst_gnt_i    = 1'b0;
    bus.inst_rvalid_i = 1'b0;
    bus.inst_rdata_i  = 32'h0;

    //            rst st fl redirect      gnt rv rdata         req addr          pc_o          inst_o        v
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h0,        32'h0,        0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h0,        32'h0,        0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h0,        32'h0,        32'h0,        0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 1, 32'h34020001, 0, 32'h0,        32'h0,        32'h0,        0));
    vecs.push_back(mk(1, 1, 0, 32'h0,        1, 0, 32'h0,        1, 32'h4,        32'h0,        32'h34020001, 1));
    vecs.push_back(mk(1, 1, 0, 32'h0,        0, 1, 32'h34030002, 0, 32'h4,        32'h0,        32'h34020001, 1));
    vecs.push_back(mk(1, 1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h8,        32'h0,        32'h34020001, 1));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h8,        32'h0,        32'h34020001, 1));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h8,        32'h4,        32'h34030002, 1));
    vecs.push_back(mk(1, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h8,        32'h4,        32'h0,        0));
    vecs.push_back(mk(1, 0, 1, 32'h100,      0, 0, 32'h0,        0, 32'h8,        32'h4,        32'h0,        0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h100,      32'h4,        32'h0,        0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 1, 32'hDEADBEEF, 0, 32'h100,      32'h4,        32'h0,        0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h100,      32'h4,        32'h0,        0));
    vecs.push_back(mk(1, 0, 1, 32'h203,      0, 1, 32'h11111111, 0, 32'h100,      32'h4,        32'h0,        0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h200,      32'h4,        32'h0,        0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 1, 32'h22222222, 0, 32'h200,      32'h4,        32'h0,        0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h204,      32'h200,      32'h22222222, 1));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h204,      32'h200,      32'h0,        0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h0,        32'h0,        0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 1, 32'h44444444, 0, 32'h0,        32'h0,        32'h0,        0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h0,        32'h0,        32'h0,        0));
    vecs.push_back(mk(1, 0, 1, 32'hFFFFFFFC, 0, 0, 32'h0,        1, 32'h0,        32'h0,        32'h0,        0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'hFFFFFFFC, 32'h0,        32'h0,        0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 1, 32'h33333333, 0, 32'hFFFFFFFC, 32'h0,        32'h0,        0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h0,        32'hFFFFFFFC, 32'h33333333, 1));
    vecs.push_back(mk(1, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h0,        32'hFFFFFFFC, 32'h0,        0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 1, 32'h34020001, 0, 32'h0,        32'hFFFFFFFC, 32'h0,        0));
    vecs.push_back(mk(1, 0, 1, 32'h40,       1, 0, 32'h0,        1, 32'h4,        32'h0,        32'h34020001, 1));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 1, 32'h55555555, 0, 32'h40,       32'h0,        32'h0,        0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h40,       32'h0,        32'h0,        0));

    for (int k = 0; k < vecs.size(); k++) apply(vecs[k], k);

    // Flush while a stalled word sits in the buffer: the word must never surface.
    hand.push_back(mk(1, 0, 0, 32'h0,  1, 0, 32'h0,        1, 32'h40, 32'h0, 32'h0, 0));
    hand.push_back(mk(1, 1, 0, 32'h0,  0, 1, 32'h66666666, 0, 32'h40, 32'h0, 32'h0, 0));
    hand.push_back(mk(1, 1, 1, 32'h80, 0, 0, 32'h0,        0, 32'h44, 32'h0, 32'h0, 0));
    hand.push_back(mk(1, 0, 0, 32'h0,  0, 0, 32'h0,        1, 32'h80, 32'h0, 32'h0, 0));
    hand.push_back(mk(1, 0, 0, 32'h0,  0, 0, 32'h0,        1, 32'h80, 32'h0, 32'h0, 0));
    for (int k = 0; k < hand.size(); k++) apply(hand[k], 100 + k);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
